// File: rtl/nano_rv32i_pkg.sv
// Shared types and constants for the nano_rv32i core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nano_rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // One buffered fetch: the instruction word together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr} with flush.
// Latency: a pushed entry is at the head on the next cycle; the head is read from registers.
// Backpressure: a push while full (without a pop) is ignored; a pop while empty is ignored; flush wins.
module fetch_fifo
    import nano_rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head_dat,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & !empty;
    assign do_push  = push & (!full | do_pop);
    assign head_dat = mem[rd_ptr];

    // Pointer/count bookkeeping and storage; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited imem requests, response buffer, branch redirect.
// Latency: grant in G, response in G+1, instruction visible to decode in G+2; redirect visible next cycle.
// Backpressure: requests stop once buffered + in-flight words would exceed DEPTH; decode stalls via instr_ready_i.
module fetch_unit
    import nano_rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            take_branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   discard_nxt;

    logic            head_taken;
    logic [SW-1:0]   credit_used;
    logic            gnt_fire;
    logic            resp_live;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    push_ent;
    fetch_entry_t    head_ent;

    // A head consumed this cycle already frees its slot, which keeps a 1-cycle memory streaming
    // one word per cycle at DEPTH=2. This term deliberately ignores take_branch_i so the redirect
    // never reaches an output combinationally (a flush frees the slot anyway).
    assign head_taken  = instr_valid_o & instr_ready_i;
    assign credit_used = SW'(fifo_count) + SW'(inflight_q) - SW'(head_taken);
    assign imem_req_o  = !rst_i && (credit_used < SW'(DEPTH));
    assign imem_addr_o = pc_q;
    assign gnt_fire    = imem_req_o & imem_gnt_i;

    // Live responses belong to the oldest outstanding request, which sits inflight words behind pc
    // whenever nothing is pending discard.
    assign resp_live   = imem_rvalid_i & (discard_q == '0) & !take_branch_i;
    assign fifo_pop    = head_taken & !take_branch_i;
    // The credit rule keeps room for every live response; the full guard only documents that.
    assign fifo_push   = resp_live & (!fifo_full | fifo_pop);
    assign push_ent    = '{pc: pc_q - (XLEN'(inflight_q) << 2), instr: imem_rdata_i};

    // Next PC and counter values from this cycle's grant, response and redirect.
    always_comb begin
        inflight_nxt = inflight_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
        discard_nxt  = discard_q;
        pc_nxt       = pc_q;
        if (gnt_fire) begin
            pc_nxt = pc_q + 32'd4;
        end
        if (imem_rvalid_i && (discard_q != '0)) begin
            discard_nxt = discard_q - CW'(1);
        end
        if (take_branch_i) begin
            pc_nxt      = word_align(branch_target_i);
            discard_nxt = inflight_nxt;
        end
    end

    // PC and credit/discard state; reset abandons everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_nxt;
            inflight_q <= inflight_nxt;
            discard_q  <= discard_nxt;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .flush    (take_branch_i),
        .head_dat (head_ent),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head_ent.instr;
    assign instr_pc_o    = head_ent.pc;

endmodule
